// File: rtl/ad9516_pkg.sv
// Shared types for the AD9516-0 configuration table: word width, address width
// and the table sequencer state encoding.
package ad9516_pkg;

    localparam int AD9516_AW = 7;
    localparam int AD9516_DW = 24;

    typedef logic [AD9516_DW-1:0] AD9516_WORD_T;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_READY,
        ST_SCAN
    } ad9516_state_t;

    // Host-supplied lengths above the physical table size saturate at 128.
    function automatic logic [7:0] ad9516_clamp_count(input logic [7:0] cnt);
        return (cnt > 8'd128) ? 8'd128 : cnt;
    endfunction

endpackage

// File: rtl/ad9516_default_rom.sv
// Synchronous default-value ROM for the AD9516-0 table (one-cycle read latency).
// Entries past DEFAULT_COUNT-1 read as zero; the last valid entry is the 0x232 update command.
module ad9516_default_rom
    import ad9516_pkg::*;
#(
    parameter int DEFAULT_COUNT = 64
) (
    input  logic                 clk,
    input  logic [AD9516_AW-1:0] addr_i,
    output AD9516_WORD_T         data_o
);

    // Word layout: R/W=0, W1:W0=00 (one byte), 13-bit register address, 8-bit data.
    function automatic AD9516_WORD_T rom_word(input logic [AD9516_AW-1:0] a);
        if (int'(a) == DEFAULT_COUNT - 1)
            return {3'b000, 13'h232, 8'h01};
        else if (int'(a) < DEFAULT_COUNT - 1)
            return {3'b000, 13'h010 + {6'b0, a}, ({1'b0, a} * 8'd37) + 8'h5A};
        else
            return '0;
    endfunction

    always_ff @(posedge clk) begin
        data_o <= rom_word(addr_i);
    end

endmodule

// File: rtl/ad9516_cfg_table.sv
// AD9516-0 SPI register table: ROM preload after reset, registered lookup for the driver.
// Define AD9516_CFG_HOST_WR_EN to add the host write port, commit and checksum rescan.
module ad9516_cfg_table
    import ad9516_pkg::*;
#(
    parameter int DEPTH         = 128,
    parameter int DEFAULT_COUNT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AD9516_AW-1:0] data_addr,
    output AD9516_WORD_T         data_to_spi,
    output logic                 adend,
`ifdef AD9516_CFG_HOST_WR_EN
    input  logic                 host_wr,
    input  logic [AD9516_AW-1:0] host_addr,
    input  AD9516_WORD_T         host_data,
    input  logic                 host_commit,
    input  logic [7:0]           host_count,
`endif
    output logic                 ready,
    output logic [7:0]           entry_count,
    output AD9516_WORD_T         table_xor
);

    ad9516_state_t        state_q;
    logic [7:0]           idx_q;
    logic                 ready_q;
    logic                 adend_q;
    AD9516_WORD_T         data_q;
    logic [7:0]           count_q;
    AD9516_WORD_T         xor_q;
    logic [DEPTH-1:0]     vld_q;
    AD9516_WORD_T         mem_q [DEPTH];
    AD9516_WORD_T         rom_q;
    logic                 ram_we;
    logic [AD9516_AW-1:0] ram_waddr;
    AD9516_WORD_T         ram_wdata;
`ifdef AD9516_CFG_HOST_WR_EN
    AD9516_WORD_T         word_q;
`endif

    ad9516_default_rom #(
        .DEFAULT_COUNT(DEFAULT_COUNT)
    ) u_rom (
        .clk   (clk),
        .addr_i(idx_q[AD9516_AW-1:0]),
        .data_o(rom_q)
    );

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = 7'(idx_q - 8'd1);
        ram_wdata = rom_q;
        if (state_q == ST_INIT && idx_q != 8'd0)
            ram_we = 1'b1;
`ifdef AD9516_CFG_HOST_WR_EN
        if (state_q == ST_READY && host_wr) begin
            ram_we    = 1'b1;
            ram_waddr = host_addr;
            ram_wdata = host_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            mem_q[ram_waddr] <= ram_wdata;
    end

    // vld_q masks RAM cells not written since reset, so stale host data never reappears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            ready_q <= 1'b0;
            adend_q <= 1'b1;
            data_q  <= '0;
            count_q <= '0;
            xor_q   <= '0;
            vld_q   <= '0;
`ifdef AD9516_CFG_HOST_WR_EN
            word_q  <= '0;
`endif
        end else begin
            if (ram_we)
                vld_q[ram_waddr] <= 1'b1;
            unique case (state_q)
                ST_INIT: begin
                    idx_q <= idx_q + 8'd1;
                    if (idx_q != 8'd0)
                        xor_q <= xor_q ^ rom_q;
                    if (idx_q == 8'(DEFAULT_COUNT)) begin
                        state_q <= ST_READY;
                        count_q <= 8'(DEFAULT_COUNT);
                        ready_q <= 1'b1;
                        idx_q   <= '0;
                    end
                end
                ST_READY: begin
`ifdef AD9516_CFG_HOST_WR_EN
                    if (host_commit) begin
                        state_q <= ST_SCAN;
                        ready_q <= 1'b0;
                        adend_q <= 1'b1;
                        count_q <= ad9516_clamp_count(host_count);
                        xor_q   <= '0;
                        idx_q   <= '0;
                    end else
`endif
                    begin
                        data_q  <= vld_q[data_addr] ? mem_q[data_addr] : '0;
                        adend_q <= ({1'b0, data_addr} >= count_q);
                    end
                end
`ifdef AD9516_CFG_HOST_WR_EN
                // RAM word fetched in one cycle is folded into the checksum the next.
                ST_SCAN: begin
                    if (idx_q != 8'd0)
                        xor_q <= xor_q ^ word_q;
                    if (idx_q == count_q) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end else begin
                        word_q <= vld_q[idx_q[AD9516_AW-1:0]] ? mem_q[idx_q[AD9516_AW-1:0]] : '0;
                        idx_q  <= idx_q + 8'd1;
                    end
                end
`endif
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign ready       = ready_q;
    assign adend       = adend_q;
    assign data_to_spi = data_q;
    assign entry_count = count_q;
    assign table_xor   = xor_q;

endmodule

// File: tb/tb_ad9516_cfg_table.sv
// Scoreboard bench for ad9516_cfg_table; host-port scenarios run when AD9516_CFG_HOST_WR_EN is defined.
module tb_ad9516_cfg_table;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  data_addr = '0;
    logic [23:0] data_to_spi;
    logic        adend;
    logic        ready;
    logic [7:0]  entry_count;
    logic [23:0] table_xor;
`ifdef AD9516_CFG_HOST_WR_EN
    logic        host_wr = 1'b0;
    logic [6:0]  host_addr = '0;
    logic [23:0] host_data = '0;
    logic        host_commit = 1'b0;
    logic [7:0]  host_count = '0;
`endif

    ad9516_cfg_table dut (
        .clk        (clk),
        .rst        (rst),
        .data_addr  (data_addr),
        .data_to_spi(data_to_spi),
        .adend      (adend),
`ifdef AD9516_CFG_HOST_WR_EN
        .host_wr    (host_wr),
        .host_addr  (host_addr),
        .host_data  (host_data),
        .host_commit(host_commit),
        .host_count (host_count),
`endif
        .ready      (ready),
        .entry_count(entry_count),
        .table_xor  (table_xor)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  a;
        logic [23:0] d;
        logic        e;
        bit          cd;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] ram_m [128];
    int          exp_count;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [23:0] rom_m(input int i);
        if (i == 63)
            return 24'h023201;
        else if (i < 63)
            return {3'b000, 13'(16 + i), 8'(i * 37 + 90)};
        else
            return 24'h0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 128; i++)
            ram_m[i] = rom_m(i);
        exp_count = 64;
    endfunction

    function automatic logic [23:0] model_xor();
        logic [23:0] x = '0;
        for (int i = 0; i < exp_count; i++)
            x ^= ram_m[i];
        return x;
    endfunction

    function automatic exp_t mk_exp(input logic [6:0] a, input bit cd);
        exp_t t;
        t.a  = a;
        t.d  = ram_m[a];
        t.e  = (int'(a) >= exp_count);
        t.cd = cd;
        return t;
    endfunction

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 400) begin
            @(posedge clk);
            n++;
            #1;
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", ready); end
        n_vec++; if (adend !== 1'b1) begin n_err++; $display("FAIL rst_adend got %b want 1", adend); end
        n_vec++; if (data_to_spi !== 24'h0) begin n_err++; $display("FAIL rst_data got %h want 0", data_to_spi); end
        n_vec++; if (entry_count !== 8'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", entry_count); end
        n_vec++; if (table_xor !== 24'h0) begin n_err++; $display("FAIL rst_xor got %h want 0", table_xor); end
        rst = 1'b0;
        wait_ready(n);
        n_vec++; if (n !== 65) begin n_err++; $display("FAIL init_cycles got %0d want 65", n); end
        n_vec++; if (entry_count !== 8'd64) begin n_err++; $display("FAIL init_count got %0d want 64", entry_count); end
        n_vec++; if (table_xor !== model_xor()) begin n_err++; $display("FAIL init_xor got %h want %h", table_xor, model_xor()); end
    endtask

    task automatic test_read();
        logic [6:0] al [10] = '{7'd5, 7'd64, 7'd0, 7'd63, 7'd127, 7'd5, 7'd1, 7'd62, 7'd65, 7'd32};
        exp_t t;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k > 0) begin
                t = sb.pop_front();
                n_vec++; if (adend !== t.e) begin n_err++; $display("FAIL read_adend[%0d] got %b want %b", t.a, adend, t.e); end
                if (t.cd) begin
                    n_vec++; if (data_to_spi !== t.d) begin n_err++; $display("FAIL read_data[%0d] got %h want %h", t.a, data_to_spi, t.d); end
                end
            end
            if (k < 10) begin
                data_addr = al[k];
                sb.push_back(mk_exp(al[k], al[k] < 64));
            end
        end
    endtask

    task automatic test_reset_mid_init();
        int n;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        n_vec++; if (ready !== 1'b0 || entry_count !== 8'd0 || table_xor !== 24'h0)
            begin n_err++; $display("FAIL midinit_rst got rdy=%b cnt=%0d xor=%h want 0/0/0", ready, entry_count, table_xor); end
        rst = 1'b0;
        wait_ready(n);
        n_vec++; if (n !== 65) begin n_err++; $display("FAIL midinit_cycles got %0d want 65", n); end
        n_vec++; if (table_xor !== model_xor()) begin n_err++; $display("FAIL midinit_xor got %h want %h", table_xor, model_xor()); end
    endtask

`ifdef AD9516_CFG_HOST_WR_EN
    task automatic commit_and_wait(input logic [7:0] cnt, output int n);
        @(negedge clk);
        host_commit = 1'b1;
        host_count  = cnt;
        @(negedge clk);
        host_commit = 1'b0;
        host_wr     = 1'b0;
        wait_ready(n);
    endtask

    task automatic test_init_write_ignored();
        int n;
        exp_t t;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            host_wr   = 1'b1;
            host_addr = k[0] ? 7'd100 : 7'd3;
            host_data = 24'hFFFFFF;
            host_commit = 1'b1;
            host_count  = 8'd10;
            @(negedge clk);
        end
        host_wr = 1'b0;
        host_commit = 1'b0;
        wait_ready(n);
        n_vec++; if (entry_count !== 8'd64) begin n_err++; $display("FAIL initwr_count got %0d want 64", entry_count); end
        n_vec++; if (table_xor !== model_xor()) begin n_err++; $display("FAIL initwr_xor got %h want %h", table_xor, model_xor()); end
        @(negedge clk);
        data_addr = 7'd3;
        sb.push_back(mk_exp(7'd3, 1'b1));
        @(negedge clk);
        t = sb.pop_front();
        n_vec++; if (data_to_spi !== t.d) begin n_err++; $display("FAIL initwr_data got %h want %h", data_to_spi, t.d); end
    endtask

    task automatic test_commit_extend();
        int n;
        exp_t t;
        logic [6:0] al [3] = '{7'd64, 7'd65, 7'd0};
        @(negedge clk);
        host_wr = 1'b1; host_addr = 7'd64; host_data = 24'h000123;
        ram_m[64] = 24'h000123;
        exp_count = 65;
        commit_and_wait(8'd65, n);
        n_vec++; if (n !== 66) begin n_err++; $display("FAIL ext_scan_cycles got %0d want 66", n); end
        n_vec++; if (entry_count !== 8'd65) begin n_err++; $display("FAIL ext_count got %0d want 65", entry_count); end
        n_vec++; if (table_xor !== model_xor()) begin n_err++; $display("FAIL ext_xor got %h want %h", table_xor, model_xor()); end
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            if (k > 0) begin
                t = sb.pop_front();
                n_vec++; if (adend !== t.e || data_to_spi !== t.d)
                    begin n_err++; $display("FAIL ext_read[%0d] got %h/%b want %h/%b", t.a, data_to_spi, adend, t.d, t.e); end
            end
            if (k < 3) begin
                data_addr = al[k];
                sb.push_back(mk_exp(al[k], 1'b1));
            end
        end
    endtask

    task automatic test_same_cycle();
        int n;
        exp_t t;
        @(negedge clk);
        host_wr = 1'b1; host_addr = 7'd0; host_data = 24'hABCDEF;
        host_commit = 1'b1; host_count = 8'd65;
        ram_m[0] = 24'hABCDEF;
        @(negedge clk);
        host_wr = 1'b0; host_commit = 1'b0;
        n_vec++; if (ready !== 1'b0 || adend !== 1'b1)
            begin n_err++; $display("FAIL same_scan_flags got rdy=%b adend=%b want 0/1", ready, adend); end
        wait_ready(n);
        n_vec++; if (n !== 66) begin n_err++; $display("FAIL same_scan_cycles got %0d want 66", n); end
        n_vec++; if (table_xor !== model_xor()) begin n_err++; $display("FAIL same_xor got %h want %h", table_xor, model_xor()); end
        @(negedge clk);
        data_addr = 7'd0;
        sb.push_back(mk_exp(7'd0, 1'b1));
        @(negedge clk);
        t = sb.pop_front();
        n_vec++; if (data_to_spi !== t.d) begin n_err++; $display("FAIL same_data got %h want %h", data_to_spi, t.d); end
    endtask

    task automatic test_commit_zero_and_clamp();
        int n;
        exp_t t;
        logic [6:0] al [3] = '{7'd0, 7'd5, 7'd127};
        logic [6:0] bl [3] = '{7'd127, 7'd100, 7'd64};
        exp_count = 0;
        commit_and_wait(8'd0, n);
        n_vec++; if (n !== 1) begin n_err++; $display("FAIL zero_scan_cycles got %0d want 1", n); end
        n_vec++; if (entry_count !== 8'd0) begin n_err++; $display("FAIL zero_count got %0d want 0", entry_count); end
        n_vec++; if (table_xor !== 24'h0) begin n_err++; $display("FAIL zero_xor got %h want 0", table_xor); end
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            if (k > 0) begin
                t = sb.pop_front();
                n_vec++; if (adend !== t.e) begin n_err++; $display("FAIL zero_adend[%0d] got %b want %b", t.a, adend, t.e); end
            end
            if (k < 3) begin
                data_addr = al[k];
                sb.push_back(mk_exp(al[k], 1'b0));
            end
        end
        exp_count = 128;
        commit_and_wait(8'd200, n);
        n_vec++; if (n !== 129) begin n_err++; $display("FAIL clamp_scan_cycles got %0d want 129", n); end
        n_vec++; if (entry_count !== 8'd128) begin n_err++; $display("FAIL clamp_count got %0d want 128", entry_count); end
        n_vec++; if (table_xor !== model_xor()) begin n_err++; $display("FAIL clamp_xor got %h want %h", table_xor, model_xor()); end
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            if (k > 0) begin
                t = sb.pop_front();
                n_vec++; if (adend !== t.e || data_to_spi !== t.d)
                    begin n_err++; $display("FAIL clamp_read[%0d] got %h/%b want %h/%b", t.a, data_to_spi, adend, t.d, t.e); end
            end
            if (k < 3) begin
                data_addr = bl[k];
                sb.push_back(mk_exp(bl[k], 1'b1));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_reset_mid_init();
        test_read();
`ifdef AD9516_CFG_HOST_WR_EN
        test_init_write_ignored();
        test_commit_extend();
        test_same_cycle();
        test_commit_zero_and_clamp();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
